// File: rtl/router_1xn_fifo_if.sv
// Packet-source and consumer-side signal bundle of the 1xN router.
// The router takes the slave modport; the source/consumers drive the master side.
interface router_1xn_fifo_if #(
  parameter int DW  = 8,
  parameter int NCH = 3
);
  logic              pkt_valid;
  logic [DW-1:0]     data_in;
  logic              busy;
  logic [NCH-1:0]    read_enb;
  logic [NCH*DW-1:0] data_out;
  logic [NCH-1:0]    vld_out;
  logic              err;
  logic              drop;
  logic [DW-1:0]     parity_calc;

  modport master (
    output pkt_valid, data_in, read_enb,
    input  busy, data_out, vld_out, err, drop, parity_calc
  );

  modport slave (
    input  pkt_valid, data_in, read_enb,
    output busy, data_out, vld_out, err, drop, parity_calc
  );
endinterface

// File: rtl/router_1xn_fifo.sv
// 1-to-NCH packet router with per-channel FIFOs and atomic packet commit.
// Words become readable only after the trailing parity word matches; otherwise they are rolled back.
module router_1xn_fifo #(
  parameter int DW     = 8,
  parameter int NCH    = 3,
  parameter int DEPTH  = 16,
  parameter int DEST_W = $clog2(NCH)
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  router_1xn_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  // One extra wrap bit lets a full FIFO be told apart from an empty one.
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DROP} state_e;

  state_e            state_q, state_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [DW-1:0]     parity_q, parity_d;
  logic              err_q, err_d;
  logic              drop_q, drop_d;
  logic              dropLate_q, dropLate_d;

  logic [PW-1:0]     wrPtr_q     [NCH];
  logic [PW-1:0]     wrPtr_d     [NCH];
  logic [PW-1:0]     commitPtr_q [NCH];
  logic [PW-1:0]     commitPtr_d [NCH];
  logic [PW-1:0]     rdPtr_q     [NCH];
  logic [PW-1:0]     rdPtr_d     [NCH];
  logic [DW-1:0]     mem_q       [NCH][DEPTH];

  logic [NCH-1:0]    chFull;
  logic [NCH-1:0]    chOversize;
  logic [NCH-1:0]    chVld;
  logic [DEST_W-1:0] destIn;
  logic [DEST_W-1:0] wrCh;
  logic              destBad;
  logic              busy;
  logic              wrEn;
  logic              commitEn;
  logic              rollbackEn;

  assign destIn  = bus.data_in[DEST_W-1:0];
  assign destBad = int'(destIn) >= NCH;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      chFull[i]     = (wrPtr_q[i] - rdPtr_q[i]) == PW'(DEPTH);
      chOversize[i] = (wrPtr_q[i] - commitPtr_q[i]) == PW'(DEPTH);
      chVld[i]      = commitPtr_q[i] != rdPtr_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    parity_d   = parity_q;
    err_d      = 1'b0;
    drop_d     = 1'b0;
    dropLate_d = dropLate_q;
    busy       = 1'b0;
    wrEn       = 1'b0;
    commitEn   = 1'b0;
    rollbackEn = 1'b0;
    wrCh       = dest_q;
    case (state_q)
      IDLE: begin
        wrCh = destIn;
        if (bus.pkt_valid) begin
          if (destBad) begin
            state_d    = DROP;
            dropLate_d = 1'b1;
          end else if (chFull[destIn]) begin
            busy = 1'b1;
          end else begin
            wrEn     = 1'b1;
            parity_d = bus.data_in;
            dest_d   = destIn;
            state_d  = LOAD;
          end
        end
      end
      LOAD: begin
        if (bus.pkt_valid) begin
          if (!chFull[dest_q]) begin
            wrEn     = 1'b1;
            parity_d = parity_q ^ bus.data_in;
          end else begin
            busy = 1'b1;
            // The packet alone fills the FIFO, so it can never be committed.
            if (chOversize[dest_q]) begin
              rollbackEn = 1'b1;
              drop_d     = 1'b1;
              dropLate_d = 1'b0;
              state_d    = DROP;
            end
          end
        end else begin
          if (bus.data_in == parity_q) begin
            commitEn = 1'b1;
          end else begin
            rollbackEn = 1'b1;
            err_d      = 1'b1;
          end
          state_d = IDLE;
        end
      end
      DROP: begin
        if (!bus.pkt_valid) begin
          drop_d     = dropLate_q;
          dropLate_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      wrPtr_d[i]     = wrPtr_q[i];
      commitPtr_d[i] = commitPtr_q[i];
      rdPtr_d[i]     = rdPtr_q[i];
      if (rollbackEn && dest_q == DEST_W'(i)) begin
        wrPtr_d[i] = commitPtr_q[i];
      end else if (wrEn && wrCh == DEST_W'(i)) begin
        wrPtr_d[i] = wrPtr_q[i] + PW'(1);
      end
      if (commitEn && dest_q == DEST_W'(i)) begin
        commitPtr_d[i] = wrPtr_q[i];
      end
      if (bus.read_enb[i] && chVld[i]) begin
        rdPtr_d[i] = rdPtr_q[i] + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q    <= IDLE;
      dest_q     <= '0;
      parity_q   <= '0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
      dropLate_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        wrPtr_q[i]     <= '0;
        commitPtr_q[i] <= '0;
        rdPtr_q[i]     <= '0;
      end
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      parity_q   <= parity_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
      dropLate_q <= dropLate_d;
      for (int i = 0; i < NCH; i++) begin
        wrPtr_q[i]     <= wrPtr_d[i];
        commitPtr_q[i] <= commitPtr_d[i];
        rdPtr_q[i]     <= rdPtr_d[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wrEn) begin
      mem_q[wrCh][wrPtr_q[wrCh][AW-1:0]] <= bus.data_in;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : gOut
    assign bus.data_out[g*DW +: DW] = mem_q[g][rdPtr_q[g][AW-1:0]];
  end

  assign bus.busy        = busy;
  assign bus.vld_out     = chVld;
  assign bus.err         = err_q;
  assign bus.drop        = drop_q;
  assign bus.parity_calc = parity_q;
endmodule

// File: tb/tb_router_1xn_fifo.sv
// Scoreboard bench for router_1xn_fifo: committed packets queue their words per channel,
// and every pop compares data_out against the head of that channel's queue.
module tb_router_1xn_fifo;
  localparam int DW    = 8;
  localparam int NCH   = 3;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic resetn;
  int   assertCount = 0;
  int   failCount   = 0;
  int   lastStalls  = 0;

  logic [DW-1:0] expQ [NCH][$];
  logic [DW-1:0] pktWords[$];

  router_1xn_fifo_if #(.DW(DW), .NCH(NCH)) bus ();

  router_1xn_fifo #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk_i    (clk),
    .resetn_i (resetn),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drives one word and holds it until the router accepts it on a rising edge.
  task automatic applyStimulus(input logic valid, input logic [DW-1:0] data);
    int stalls = 0;
    bus.pkt_valid = valid;
    bus.data_in   = data;
    #1;
    while (bus.busy && stalls < 200) begin
      @(posedge clk); #1;
      stalls++;
    end
    if (stalls >= 200) checkOutput("busyTimeout", 32'(stalls), 0);
    lastStalls += stalls;
    @(posedge clk); #1;
  endtask

  task automatic newPacket(input logic [DW-1:0] hdr, input logic [DW-1:0] first,
                           input logic [DW-1:0] step, input int nPayload);
    logic [DW-1:0] w = first;
    pktWords.delete();
    pktWords.push_back(hdr);
    for (int k = 0; k < nPayload; k++) begin
      pktWords.push_back(w);
      w = w + step;
    end
  endtask

  function automatic logic [DW-1:0] pktParity();
    logic [DW-1:0] p = '0;
    foreach (pktWords[k]) p = p ^ pktWords[k];
    return p;
  endfunction

  task automatic sendBody();
    foreach (pktWords[k]) applyStimulus(1'b1, pktWords[k]);
  endtask

  task automatic sendParity(input bit corrupt);
    logic [DW-1:0] p = pktParity();
    applyStimulus(1'b0, corrupt ? ~p : p);
  endtask

  task automatic pushExpected(input int ch);
    foreach (pktWords[k]) expQ[ch].push_back(pktWords[k]);
  endtask

  task automatic drainChannel(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      int waitCnt = 0;
      logic [DW-1:0] exp = '0;
      while (!bus.vld_out[ch] && waitCnt < 50) begin
        @(posedge clk); #1;
        waitCnt++;
      end
      checkOutput("rdVld", 32'(bus.vld_out[ch]), 1);
      checkOutput("rdQueueNonEmpty", 32'(expQ[ch].size() > 0), 1);
      if (expQ[ch].size() > 0) exp = expQ[ch].pop_front();
      checkOutput("rdData", 32'(bus.data_out[ch*DW +: DW]), 32'(exp));
      bus.read_enb[ch] = 1'b1;
      @(posedge clk); #1;
      bus.read_enb[ch] = 1'b0;
    end
  endtask

  initial begin
    logic [DW-1:0] popped;
    bus.pkt_valid = 1'b0;
    bus.data_in   = '0;
    bus.read_enb  = '0;
    resetn        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstBusy",   32'(bus.busy), 0);
    checkOutput("rstVld",    32'(bus.vld_out), 0);
    checkOutput("rstErr",    32'(bus.err), 0);
    checkOutput("rstDrop",   32'(bus.drop), 0);
    checkOutput("rstParity", 32'(bus.parity_calc), 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] good packet to channel 2");
    newPacket(8'hAA, 8'h11, 8'h11, 5);
    sendBody();
    checkOutput("goodNoEarlyVld", 32'(bus.vld_out), 0);
    sendParity(1'b0);
    checkOutput("goodVld",    32'(bus.vld_out), 32'b100);
    checkOutput("goodErr",    32'(bus.err), 0);
    checkOutput("goodDrop",   32'(bus.drop), 0);
    checkOutput("goodParity", 32'(bus.parity_calc), 32'(pktParity()));
    pushExpected(2);
    drainChannel(2, 6);
    checkOutput("goodVldAfterDrain", 32'(bus.vld_out[2]), 0);

    $display("[TB] bad parity to channel 0");
    newPacket(8'hAC, 8'h11, 8'h11, 5);
    sendBody();
    sendParity(1'b1);
    checkOutput("badErrPulse", 32'(bus.err), 1);
    checkOutput("badNoVld",    32'(bus.vld_out[0]), 0);
    @(posedge clk); #1;
    checkOutput("badErrEnd",   32'(bus.err), 0);
    checkOutput("badNoVldLater", 32'(bus.vld_out[0]), 0);
    newPacket(8'hAC, 8'h66, 8'h11, 2);
    sendBody();
    sendParity(1'b0);
    checkOutput("recoverVld", 32'(bus.vld_out), 32'b001);
    checkOutput("recoverErr", 32'(bus.err), 0);
    pushExpected(0);
    drainChannel(0, 3);

    $display("[TB] invalid destination");
    lastStalls = 0;
    newPacket(8'hAB, 8'h01, 8'h01, 2);
    sendBody();
    sendParity(1'b0);
    checkOutput("invDrop",   32'(bus.drop), 1);
    checkOutput("invErr",    32'(bus.err), 0);
    checkOutput("invVld",    32'(bus.vld_out), 0);
    checkOutput("invNoBusy", 32'(lastStalls), 0);
    @(posedge clk); #1;
    checkOutput("invDropEnd", 32'(bus.drop), 0);

    $display("[TB] backpressure on channel 1");
    newPacket(8'h01, 8'h10, 8'h01, 7);
    sendBody();
    sendParity(1'b0);
    checkOutput("bpFillErrA", 32'(bus.err), 0);
    pushExpected(1);
    newPacket(8'h05, 8'h20, 8'h01, 7);
    sendBody();
    sendParity(1'b0);
    checkOutput("bpFillErrB", 32'(bus.err), 0);
    pushExpected(1);
    checkOutput("bpFillVld", 32'(bus.vld_out), 32'b010);
    newPacket(8'h09, 8'h31, 8'h01, 2);
    for (int k = 0; k < 3; k++) begin
      bus.pkt_valid = 1'b1;
      bus.data_in   = pktWords[k];
      #1;
      checkOutput("bpBusyFull", 32'(bus.busy), 1);
      if (k == 0) begin
        @(posedge clk); #1;
        checkOutput("bpBusyHold", 32'(bus.busy), 1);
      end
      popped = expQ[1].pop_front();
      checkOutput("bpPopData", 32'(bus.data_out[1*DW +: DW]), 32'(popped));
      bus.read_enb[1] = 1'b1;
      @(posedge clk); #1;
      bus.read_enb[1] = 1'b0;
      #1;
      checkOutput("bpBusyFreed", 32'(bus.busy), 0);
      @(posedge clk); #1;
    end
    sendParity(1'b0);
    checkOutput("bpErr", 32'(bus.err), 0);
    pushExpected(1);
    drainChannel(1, 16);
    checkOutput("bpEmpty", 32'(bus.vld_out), 0);

    $display("[TB] oversize packet to channel 0");
    lastStalls = 0;
    newPacket(8'h00, 8'h01, 8'h01, 19);
    for (int k = 0; k < 16; k++) applyStimulus(1'b1, pktWords[k]);
    checkOutput("ovNoStallFirst16", 32'(lastStalls), 0);
    bus.pkt_valid = 1'b1;
    bus.data_in   = pktWords[16];
    #1;
    checkOutput("ovBusy17", 32'(bus.busy), 1);
    @(posedge clk); #1;
    checkOutput("ovDrop",   32'(bus.drop), 1);
    checkOutput("ovBusyOff", 32'(bus.busy), 0);
    checkOutput("ovErr",    32'(bus.err), 0);
    lastStalls = 0;
    for (int k = 16; k < 20; k++) applyStimulus(1'b1, pktWords[k]);
    sendParity(1'b0);
    checkOutput("ovNoStallRest", 32'(lastStalls), 0);
    checkOutput("ovDropOnce", 32'(bus.drop), 0);
    checkOutput("ovErrEnd",   32'(bus.err), 0);
    checkOutput("ovEmpty",    32'(bus.vld_out), 0);

    $display("[TB] reset mid-packet");
    newPacket(8'h02, 8'h41, 8'h01, 2);
    sendBody();
    sendParity(1'b0);
    checkOutput("rstPreVld", 32'(bus.vld_out), 32'b100);
    pushExpected(2);
    applyStimulus(1'b1, 8'h06);
    applyStimulus(1'b1, 8'h51);
    bus.pkt_valid = 1'b1;
    bus.data_in   = 8'h52;
    resetn        = 1'b0;
    @(posedge clk); #1;
    checkOutput("midRstBusy",   32'(bus.busy), 0);
    checkOutput("midRstVld",    32'(bus.vld_out), 0);
    checkOutput("midRstErr",    32'(bus.err), 0);
    checkOutput("midRstDrop",   32'(bus.drop), 0);
    checkOutput("midRstParity", 32'(bus.parity_calc), 0);
    expQ[2].delete();
    bus.pkt_valid = 1'b0;
    resetn        = 1'b1;
    @(posedge clk); #1;
    newPacket(8'h0E, 8'h61, 8'h01, 2);
    sendBody();
    sendParity(1'b0);
    checkOutput("postRstVld", 32'(bus.vld_out), 32'b100);
    pushExpected(2);
    drainChannel(2, 3);
    checkOutput("postRstEmpty", 32'(bus.vld_out), 0);

    checkOutput("queuesEmpty", 32'(expQ[0].size() + expQ[1].size() + expQ[2].size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
